// File: rtl/ctrl_msg_merger.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_msg_merger
// Purpose  : Merges per-core single-beat control messages into one stream,
//            buffering each core in a small FIFO with round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_msg_merger #(
    parameter int CORE_COUNT     = 16,
    parameter int DATA_WIDTH     = 64,
    parameter int CORE_CNT_WIDTH = $clog2(CORE_COUNT),
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic [CORE_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [CORE_COUNT-1:0]            s_axis_tvalid,
    output logic [CORE_COUNT-1:0]            s_axis_tready,
    input  logic [CORE_COUNT-1:0]            s_axis_tlast,

    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic [CORE_CNT_WIDTH-1:0]        m_axis_tuser
);

    localparam int                 c_PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_WIDTH = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_CNT_WIDTH-1:0] c_FULL  = c_CNT_WIDTH'(FIFO_DEPTH);

    logic [CORE_COUNT-1:0]               w_req;
    logic [CORE_COUNT-1:0]               w_pop;
    logic [CORE_COUNT-1:0][DATA_WIDTH:0] w_head;
    logic                                w_load;
    logic                                w_grant_vld;
    logic [CORE_CNT_WIDTH-1:0]           w_grant_idx;
    logic [CORE_CNT_WIDTH-1:0]           w_scan_idx;
    int                                  w_scan_sum;

    logic [CORE_CNT_WIDTH-1:0]           r_last_grant;
    logic [DATA_WIDTH-1:0]               r_m_tdata;
    logic                                r_m_tvalid;
    logic                                r_m_tlast;
    logic [CORE_CNT_WIDTH-1:0]           r_m_tuser;

    // ------------------------------------------------------------------------
    // Per-core FIFOs; each entry stores {tlast, tdata}.
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < CORE_COUNT; i++) begin : g_core
        logic [DATA_WIDTH:0]      r_mem [FIFO_DEPTH];
        logic [c_PTR_WIDTH-1:0]   r_wr_ptr;
        logic [c_PTR_WIDTH-1:0]   r_rd_ptr;
        logic [c_CNT_WIDTH-1:0]   r_count;
        logic                     w_push;

        assign s_axis_tready[i] = (r_count != c_FULL);
        assign w_push           = s_axis_tvalid[i] & s_axis_tready[i];
        assign w_req[i]         = (r_count != '0);
        assign w_pop[i]         = w_load & w_grant_vld &
                                  (w_grant_idx == CORE_CNT_WIDTH'(i));
        assign w_head[i]        = r_mem[r_rd_ptr];

        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {s_axis_tlast[i],
                                    s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH]};
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_WIDTH'(1);
                end
                if (w_pop[i]) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_WIDTH'(1);
                end
                case ({w_push, w_pop[i]})
                    2'b10:   r_count <= r_count + c_CNT_WIDTH'(1);
                    2'b01:   r_count <= r_count - c_CNT_WIDTH'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin: scan upward from the core after the last grant, wrapping.
    // ------------------------------------------------------------------------
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_scan_sum  = 0;
        w_scan_idx  = '0;
        for (int off = 1; off <= CORE_COUNT; off++) begin
            w_scan_sum = int'(r_last_grant) + off;
            if (w_scan_sum >= CORE_COUNT) begin
                w_scan_sum = w_scan_sum - CORE_COUNT;
            end
            w_scan_idx = CORE_CNT_WIDTH'(w_scan_sum);
            if (!w_grant_vld && w_req[w_scan_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_scan_idx;
            end
        end
    end

    assign w_load = ~r_m_tvalid | m_axis_tready;

    // Output register; contents stay frozen while a beat is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_tvalid   <= 1'b0;
            r_m_tdata    <= '0;
            r_m_tlast    <= 1'b0;
            r_m_tuser    <= '0;
            r_last_grant <= CORE_CNT_WIDTH'(CORE_COUNT - 1);
        end else if (w_load) begin
            if (w_grant_vld) begin
                r_m_tvalid   <= 1'b1;
                r_m_tdata    <= w_head[w_grant_idx][DATA_WIDTH-1:0];
                r_m_tlast    <= w_head[w_grant_idx][DATA_WIDTH];
                r_m_tuser    <= w_grant_idx;
                r_last_grant <= w_grant_idx;
            end else begin
                r_m_tvalid   <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tuser  = r_m_tuser;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_msg_merger.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_msg_merger
// Purpose  : Directed and randomized self-checking bench for ctrl_msg_merger.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_msg_merger;

    localparam int c_CORES = 16;
    localparam int c_DW    = 64;
    localparam int c_CW    = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [c_CORES*c_DW-1:0]   s_axis_tdata;
    logic [c_CORES-1:0]        s_axis_tvalid;
    logic [c_CORES-1:0]        s_axis_tready;
    logic [c_CORES-1:0]        s_axis_tlast;
    logic [c_DW-1:0]           m_axis_tdata;
    logic                      m_axis_tvalid;
    logic                      m_axis_tready;
    logic                      m_axis_tlast;
    logic [c_CW-1:0]           m_axis_tuser;

    int n_vec = 0;
    int n_err = 0;

    // Per-core expected-message rings, entries are {tlast, tdata}.
    logic [c_DW:0] sb_mem [c_CORES][16];
    int            sb_wr  [c_CORES];
    int            sb_rd  [c_CORES];

    always #5 clk = ~clk;

    ctrl_msg_merger #(
        .CORE_COUNT     (c_CORES),
        .DATA_WIDTH     (c_DW),
        .CORE_CNT_WIDTH (c_CW),
        .FIFO_DEPTH     (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser)
    );

    task automatic idle_inputs();
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = '0;
    endtask

    task automatic sb_clear();
        for (int i = 0; i < c_CORES; i++) begin
            sb_wr[i] = 0;
            sb_rd[i] = 0;
        end
    endtask

    task automatic sb_push(input int c, input logic [c_DW-1:0] d, input logic l);
        sb_mem[c][sb_wr[c] % 16] = {l, d};
        sb_wr[c]++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        m_axis_tready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb_clear();
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if (m_axis_tvalid !== 1'b0) begin
            n_err++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid);
        end
        n_vec++;
        if (m_axis_tdata !== '0) begin
            n_err++; $display("FAIL reset_tdata: got %h expected 0", m_axis_tdata);
        end
        n_vec++;
        if (m_axis_tlast !== 1'b0 || m_axis_tuser !== '0) begin
            n_err++; $display("FAIL reset_tlast_tuser: got %b/%0d expected 0/0", m_axis_tlast, m_axis_tuser);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (s_axis_tready !== '1) begin
            n_err++; $display("FAIL reset_s_tready: got %h expected ffff", s_axis_tready);
        end
        n_vec++;
        if (m_axis_tvalid !== 1'b0) begin
            n_err++; $display("FAIL reset_idle_tvalid: got %b expected 0", m_axis_tvalid);
        end
    endtask

    task automatic test_single();
        int extra;
        do_reset();
        s_axis_tdata[5*c_DW +: c_DW] = 64'h0000_0000_0003_0040;
        s_axis_tlast[5]  = 1'b1;
        s_axis_tvalid[5] = 1'b1;
        @(negedge clk);
        idle_inputs();
        n_vec++;
        if (m_axis_tvalid !== 1'b0) begin
            n_err++; $display("FAIL single_early: got tvalid %b expected 0", m_axis_tvalid);
        end
        @(negedge clk);
        n_vec++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'h0000_0000_0003_0040 ||
            m_axis_tuser !== c_CW'(5) || m_axis_tlast !== 1'b1) begin
            n_err++;
            $display("FAIL single_beat: got v=%b d=%h u=%0d l=%b expected v=1 d=0000000000030040 u=5 l=1",
                     m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast);
        end
        extra = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (m_axis_tvalid) extra++;
        end
        n_vec++;
        if (extra != 0) begin
            n_err++; $display("FAIL single_extra: got %0d extra beats expected 0", extra);
        end
    endtask

    task automatic test_all_cores();
        int t;
        do_reset();
        for (int i = 0; i < c_CORES; i++) begin
            s_axis_tdata[i*c_DW +: c_DW] = c_DW'(i);
        end
        s_axis_tvalid = '1;
        @(negedge clk);
        idle_inputs();
        for (t = 0; t < 10 && !m_axis_tvalid; t++) @(negedge clk);
        n_vec++;
        if (t != 1) begin
            n_err++; $display("FAIL all_latency: got %0d wait cycles expected 1", t);
        end
        for (int k = 0; k < c_CORES; k++) begin
            n_vec++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tuser !== c_CW'(k) || m_axis_tdata !== c_DW'(k)) begin
                n_err++;
                $display("FAIL all_seq beat %0d: got v=%b u=%0d d=%h expected v=1 u=%0d d=%h",
                         k, m_axis_tvalid, m_axis_tuser, m_axis_tdata, k, c_DW'(k));
            end
            @(negedge clk);
        end
        n_vec++;
        if (m_axis_tvalid !== 1'b0) begin
            n_err++; $display("FAIL all_extra: got tvalid %b expected 0", m_axis_tvalid);
        end
    endtask

    task automatic test_backpressure();
        int seq [c_CORES];
        int c, k, gaps;
        logic [c_DW-1:0] d;
        do_reset();
        for (int i = 0; i < c_CORES; i++) seq[i] = 0;
        m_axis_tready = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            for (int i = 0; i < c_CORES; i++) begin
                d = {32'(seq[i]), 32'(i)};
                s_axis_tvalid[i] = 1'b1;
                s_axis_tdata[i*c_DW +: c_DW] = d;
                s_axis_tlast[i] = seq[i][0];
                if (s_axis_tready[i]) begin
                    sb_push(i, d, seq[i][0]);
                    seq[i]++;
                end
            end
            @(negedge clk);
            if (cyc >= 1) begin
                n_vec++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tuser !== '0 || m_axis_tdata !== '0) begin
                    n_err++;
                    $display("FAIL bp_hold cyc %0d: got v=%b u=%0d d=%h expected v=1 u=0 d=0",
                             cyc, m_axis_tvalid, m_axis_tuser, m_axis_tdata);
                end
            end
        end
        idle_inputs();
        for (int i = 0; i < c_CORES; i++) begin
            n_vec++;
            if (seq[i] != ((i == 0) ? 3 : 2)) begin
                n_err++; $display("FAIL bp_accepted core %0d: got %0d expected %0d", i, seq[i], (i == 0) ? 3 : 2);
            end
        end
        n_vec++;
        if (s_axis_tready !== '0) begin
            n_err++; $display("FAIL bp_s_tready: got %h expected 0000", s_axis_tready);
        end
        m_axis_tready = 1'b1;
        k = 0;
        gaps = 0;
        for (int t = 0; t < 60 && k < 33; t++) begin
            if (m_axis_tvalid) begin
                c = int'(m_axis_tuser);
                n_vec++;
                if (sb_rd[c] == sb_wr[c] || m_axis_tuser !== c_CW'(k % 16) ||
                    sb_mem[c][sb_rd[c] % 16] !== {m_axis_tlast, m_axis_tdata}) begin
                    n_err++;
                    $display("FAIL bp_drain beat %0d: got u=%0d d=%h expected u=%0d d=%h",
                             k, m_axis_tuser, m_axis_tdata, k % 16, sb_mem[c][sb_rd[c] % 16]);
                end
                if (sb_rd[c] != sb_wr[c]) sb_rd[c]++;
                k++;
            end else begin
                gaps++;
            end
            @(negedge clk);
        end
        n_vec++;
        if (k != 33 || gaps != 0) begin
            n_err++; $display("FAIL bp_drain_count: got %0d beats %0d gaps expected 33 beats 0 gaps", k, gaps);
        end
        n_vec++;
        if (m_axis_tvalid !== 1'b0) begin
            n_err++; $display("FAIL bp_drain_end: got tvalid %b expected 0", m_axis_tvalid);
        end
    endtask

    task automatic test_fairness();
        int seq3, seq9, c, ng, t12, n12, viol, gaps;
        int grants [64];
        logic [c_DW-1:0] d;
        do_reset();
        seq3 = 0; seq9 = 0; ng = 0; t12 = -1; n12 = 0; viol = 0; gaps = 0;
        for (int t = 0; t < 30; t++) begin
            if (m_axis_tvalid) begin
                c = int'(m_axis_tuser);
                n_vec++;
                if (sb_rd[c] == sb_wr[c] || sb_mem[c][sb_rd[c] % 16] !== {m_axis_tlast, m_axis_tdata}) begin
                    n_err++;
                    $display("FAIL fair_data t %0d: got u=%0d d=%h expected d=%h",
                             t, c, m_axis_tdata, sb_mem[c][sb_rd[c] % 16]);
                end
                if (sb_rd[c] != sb_wr[c]) sb_rd[c]++;
                grants[ng] = c;
                ng++;
                if (c == 12) begin
                    n12++;
                    t12 = t;
                end
            end else if (t >= 2) begin
                gaps++;
            end
            idle_inputs();
            d = {32'(seq3), 32'd3};
            s_axis_tvalid[3] = 1'b1;
            s_axis_tdata[3*c_DW +: c_DW] = d;
            if (s_axis_tready[3]) begin
                sb_push(3, d, 1'b0);
                seq3++;
            end
            d = {32'(seq9), 32'd9};
            s_axis_tvalid[9] = 1'b1;
            s_axis_tdata[9*c_DW +: c_DW] = d;
            if (s_axis_tready[9]) begin
                sb_push(9, d, 1'b0);
                seq9++;
            end
            if (t == 8) begin
                d = 64'h0000_0C0C_0000_000C;
                s_axis_tvalid[12] = 1'b1;
                s_axis_tdata[12*c_DW +: c_DW] = d;
                s_axis_tlast[12] = 1'b1;
                if (s_axis_tready[12]) sb_push(12, d, 1'b1);
            end
            @(negedge clk);
        end
        idle_inputs();
        for (int k = 1; k < ng; k++) begin
            if (grants[k] != 12 && grants[k-1] != 12 && grants[k] == grants[k-1]) viol++;
        end
        n_vec++;
        if (grants[0] != 3) begin
            n_err++; $display("FAIL fair_first: got %0d expected 3", grants[0]);
        end
        n_vec++;
        if (viol != 0) begin
            n_err++; $display("FAIL fair_alternate: got %0d repeats expected 0", viol);
        end
        n_vec++;
        if (n12 != 1 || (t12 != 10 && t12 != 11)) begin
            n_err++; $display("FAIL fair_core12: got %0d grants at t=%0d expected 1 at t=10 or 11", n12, t12);
        end
        n_vec++;
        if (gaps != 0) begin
            n_err++; $display("FAIL fair_throughput: got %0d idle cycles expected 0", gaps);
        end
    endtask

    task automatic test_reset_mid();
        int beats;
        do_reset();
        m_axis_tready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            s_axis_tvalid[c] = 1'b1;
            s_axis_tdata[c*c_DW +: c_DW] = {32'hDEAD0000, 32'(c)};
        end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        n_vec++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tuser !== '0) begin
            n_err++; $display("FAIL rm_pending: got v=%b u=%0d expected v=1 u=0", m_axis_tvalid, m_axis_tuser);
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (m_axis_tvalid !== 1'b0) begin
            n_err++; $display("FAIL rm_tvalid: got %b expected 0", m_axis_tvalid);
        end
        n_vec++;
        if (s_axis_tready !== '1) begin
            n_err++; $display("FAIL rm_s_tready: got %h expected ffff", s_axis_tready);
        end
        rst = 1'b0;
        s_axis_tvalid[7] = 1'b1;
        s_axis_tdata[7*c_DW +: c_DW] = 64'h0000_7777_0000_0007;
        m_axis_tready = 1'b1;
        @(negedge clk);
        idle_inputs();
        beats = 0;
        for (int t = 0; t < 20; t++) begin
            if (m_axis_tvalid) begin
                beats++;
                n_vec++;
                if (m_axis_tuser !== c_CW'(7) || m_axis_tdata !== 64'h0000_7777_0000_0007) begin
                    n_err++;
                    $display("FAIL rm_beat: got u=%0d d=%h expected u=7 d=0000777700000007", m_axis_tuser, m_axis_tdata);
                end
            end
            @(negedge clk);
        end
        n_vec++;
        if (beats != 1) begin
            n_err++; $display("FAIL rm_count: got %0d beats expected 1", beats);
        end
    endtask

    task automatic test_random();
        int sent, recv, c, left;
        logic [c_DW-1:0] d;
        logic l;
        do_reset();
        sent = 0;
        recv = 0;
        for (int t = 0; t < 20000 && (sent < 1000 || recv < sent); t++) begin
            m_axis_tready = ($urandom_range(0, 3) != 0);
            if (m_axis_tvalid && m_axis_tready) begin
                c = int'(m_axis_tuser);
                n_vec++;
                if (sb_rd[c] == sb_wr[c] || sb_mem[c][sb_rd[c] % 16] !== {m_axis_tlast, m_axis_tdata}) begin
                    n_err++;
                    $display("FAIL rand_beat %0d: got u=%0d l=%b d=%h expected %h",
                             recv, c, m_axis_tlast, m_axis_tdata, sb_mem[c][sb_rd[c] % 16]);
                end
                if (sb_rd[c] != sb_wr[c]) sb_rd[c]++;
                recv++;
            end
            idle_inputs();
            for (int i = 0; i < c_CORES; i++) begin
                if (sent < 1000 && $urandom_range(0, 7) == 0) begin
                    d = {$urandom, $urandom};
                    l = 1'($urandom_range(0, 1));
                    s_axis_tvalid[i] = 1'b1;
                    s_axis_tdata[i*c_DW +: c_DW] = d;
                    s_axis_tlast[i] = l;
                    if (s_axis_tready[i]) begin
                        sb_push(i, d, l);
                        sent++;
                    end
                end
            end
            @(negedge clk);
        end
        idle_inputs();
        left = 0;
        for (int i = 0; i < c_CORES; i++) left += sb_wr[i] - sb_rd[i];
        n_vec++;
        if (sent != 1000 || recv != 1000) begin
            n_err++; $display("FAIL rand_count: got sent=%0d recv=%0d expected 1000/1000", sent, recv);
        end
        n_vec++;
        if (left != 0) begin
            n_err++; $display("FAIL rand_leftover: got %0d undelivered expected 0", left);
        end
        n_vec++;
        if (m_axis_tvalid !== 1'b0) begin
            n_err++; $display("FAIL rand_end: got tvalid %b expected 0", m_axis_tvalid);
        end
    endtask

    initial begin
        rst = 1'b1;
        m_axis_tready = 1'b0;
        idle_inputs();
        sb_clear();
        test_reset();
        test_single();
        test_all_cores();
        test_backpressure();
        test_fairness();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
